mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single-outstanding
// memory interface, with a per-access WAIT timeout that completes the access with an error.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IReq,
  input  logic        DReq,
  input  logic [31:0] IAddr,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic        DWEn,
  output logic        IVld,
  output logic        DVld,
  output logic [31:0] IData,
  output logic [31:0] DData,
  output logic        IErr,
  output logic        DErr,
  output logic        RRdy,
  output logic [31:0] RAddr,
  output logic [31:0] RWData,
  output logic        RWEn,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic [1:0]  dbg_state
);

  // Handshakes: a port holds Req (and its address/data) until its one-cycle Vld;
  // RRdy is a one-cycle issue strobe, RVld a one-cycle response honoured only in WAIT.

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic          last_d;
  logic          gnt_d;
  logic          req_wen;
  logic [CW-1:0] wait_cnt;

  logic          pick_d;
  logic          resp_fire;
  logic          resp_err;
  logic [31:0]   resp_data;

  // D wins when it is the only requester, or on a tie when I was granted last.
  assign pick_d = DReq & (~IReq | ~last_d);

  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (RVld) begin
      resp_fire = 1'b1;
      resp_data = req_wen ? 32'd0 : RData;
    end else if (wait_cnt == CNT_LAST) begin
      resp_fire = 1'b1;
      resp_err  = 1'b1;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      gnt_d    <= 1'b0;
      req_wen  <= 1'b0;
      wait_cnt <= '0;
      RRdy     <= 1'b0;
      RAddr    <= '0;
      RWData   <= '0;
      RWEn     <= 1'b0;
      IVld     <= 1'b0;
      DVld     <= 1'b0;
      IErr     <= 1'b0;
      DErr     <= 1'b0;
      IData    <= '0;
      DData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IReq || DReq) begin
            gnt_d   <= pick_d;
            last_d  <= pick_d;
            req_wen <= pick_d & DWEn;
            RRdy    <= 1'b1;
            RAddr   <= pick_d ? DAddr : IAddr;
            RWData  <= pick_d ? DWData : 32'd0;
            RWEn    <= pick_d & DWEn;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          RRdy     <= 1'b0;
          RWEn     <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (resp_fire) begin
            IVld  <= ~gnt_d;
            DVld  <= gnt_d;
            IErr  <= ~gnt_d & resp_err;
            DErr  <= gnt_d & resp_err;
            IData <= gnt_d ? 32'd0 : resp_data;
            DData <= gnt_d ? resp_data : 32'd0;
            state <= RESP;
          end else begin
            // Stops at CNT_LAST because resp_fire forces the exit there.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          IVld  <= 1'b0;
          DVld  <= 1'b0;
          IErr  <= 1'b0;
          DErr  <= 1'b0;
          IData <= '0;
          DData <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder model, request driver tasks,
// and a queue-based scoreboard monitor checking every Vld pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IReq = 1'b0, DReq = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0;
  logic        DWEn = 1'b0;
  logic        IVld, DVld, IErr, DErr, RRdy, RWEn;
  logic [31:0] IData, DData, RAddr, RWData;
  logic        RVld = 1'b0;
  logic [31:0] RData = '0;
  logic [1:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .IReq(IReq), .DReq(DReq), .IAddr(IAddr), .DAddr(DAddr),
    .DWData(DWData), .DWEn(DWEn), .IVld(IVld), .DVld(DVld), .IData(IData), .DData(DData),
    .IErr(IErr), .DErr(DErr), .RRdy(RRdy), .RAddr(RAddr), .RWData(RWData), .RWEn(RWEn),
    .RVld(RVld), .RData(RData), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- memory responder model ----------------
  logic [31:0] mem [logic [31:0]];
  bit          pend = 0, stall = 0, stray = 0;
  logic [31:0] pend_data = '0;
  int          rrdy_cnt = 0, rrdy_cyc = -1;
  logic [31:0] rrdy_addr = '0;

  always @(negedge clk) begin
    RVld  = 1'b0;
    RData = '0;
    if (pend) begin
      pend = 0;
      if (!stall) begin
        RVld  = 1'b1;
        RData = pend_data;
      end
    end
    if (stray) RVld = 1'b1;
    if (RRdy && !rst) begin
      rrdy_cnt++;
      rrdy_cyc  = cyc;
      rrdy_addr = RAddr;
      if (RWEn) begin
        mem[RAddr] = RWData;
        pend_data  = 32'hFFFF0000;
      end else begin
        pend_data = mem.exists(RAddr) ? mem[RAddr] : 32'd0;
      end
      pend = 1;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {port (1=D), err, data}
  logic [33:0] exp_q[$];

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && (IVld || DVld)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", {IVld, DVld}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("vld_port", {IVld, DVld}, e[33] ? 2'b01 : 2'b10);
        if (DVld) begin
          chk("d_resp", {DErr, DData}, e[32:0]);
          chk("i_quiet", {IErr, IData}, 33'd0);
        end else begin
          chk("i_resp", {IErr, IData}, e[32:0]);
          chk("d_quiet", {DErr, DData}, 33'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int t0;

  task automatic wait_vld(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (IVld || DVld) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("vld_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; IReq = 1'b0; DReq = 1'b0; DWEn = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic req_one(input bit d, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wen, input logic [33:0] exp, input int lat, input string name);
    int at;
    @(posedge clk); #1;
    t0 = cyc;
    if (d) begin
      DAddr = addr; DWData = wdata; DWEn = wen; DReq = 1'b1;
    end else begin
      IAddr = addr; IReq = 1'b1;
    end
    exp_q.push_back(exp);
    wait_vld(lat + 6, at);
    chk(name, at - t0, lat);
    @(posedge clk); #1;
    IReq = 1'b0; DReq = 1'b0; DWEn = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int at0, at1, at2, rc;
    mem[32'h100] = 32'h00A00093;
    mem[32'h200] = 32'h11223344;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {RRdy, RWEn, IVld, DVld, IErr, DErr}, 6'd0);
    chk("rst_bus", RAddr | RWData | IData | DData, 32'd0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1 rst = 1'b0;

    // I read, nominal latency, issue strobe timing and address
    req_one(0, 32'h100, 32'd0, 0, {1'b0, 1'b0, 32'h00A00093}, 3, "i_read_lat");
    chk("rrdy_cycle", rrdy_cyc - t0, 1);
    chk("rrdy_addr", rrdy_addr, 32'h100);
    chk("rrdy_count", rrdy_cnt, 1);

    // D write then read back
    req_one(1, 32'h105, 32'hDEADBEEF, 1, {1'b1, 1'b0, 32'h0}, 3, "d_write_lat");
    req_one(1, 32'h105, 32'h0, 0, {1'b1, 1'b0, 32'hDEADBEEF}, 3, "d_read_lat");

    // tie after reset: D, I, D, 4 cycles apart
    do_reset(2);
    @(posedge clk); #1;
    t0 = cyc;
    IAddr = 32'h100; DAddr = 32'h200; DWEn = 1'b0;
    IReq = 1'b1; DReq = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    exp_q.push_back({1'b0, 1'b0, 32'h00A00093});
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    wait_vld(10, at0);
    wait_vld(10, at1);
    wait_vld(10, at2);
    @(posedge clk); #1 IReq = 1'b0; DReq = 1'b0;
    chk("tie_first_lat", at0 - t0, 3);
    chk("tie_gap1", at1 - at0, 4);
    chk("tie_gap2", at2 - at1, 4);

    // timeout: 16 WAIT cycles then error response, then normal service
    stall = 1;
    req_one(1, 32'h200, 32'd0, 0, {1'b1, 1'b1, 32'h0}, 18, "timeout_lat");
    stall = 0;
    req_one(0, 32'h100, 32'd0, 0, {1'b0, 1'b0, 32'h00A00093}, 3, "after_timeout_lat");

    // reset during WAIT abandons the access
    @(posedge clk); #1;
    IAddr = 32'h100; IReq = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; IReq = 1'b0;
    @(negedge clk);
    chk("pre_rst_state", dbg_state, 2'd2);
    @(negedge clk);
    chk("wait_rst_ctrl", {RRdy, RWEn, IVld, DVld, IErr, DErr}, 6'd0);
    chk("wait_rst_bus", RAddr | RWData | IData | DData, 32'd0);
    chk("wait_rst_state", dbg_state, 2'd0);
    @(posedge clk); #1 rst = 1'b0;
    req_one(0, 32'h100, 32'd0, 0, {1'b0, 1'b0, 32'h00A00093}, 3, "post_rst_lat");

    // tie where I drops during D's access: I must be forgotten
    @(posedge clk); #1;
    t0 = cyc;
    IAddr = 32'h100; DAddr = 32'h200; IReq = 1'b1; DReq = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'h11223344});
    @(posedge clk); #1 IReq = 1'b0;
    wait_vld(8, at0);
    chk("drop_lat", at0 - t0, 3);
    @(posedge clk); #1 DReq = 1'b0;
    rc = rrdy_cnt;
    repeat (8) @(posedge clk);
    chk("drop_no_issue", rrdy_cnt - rc, 0);

    // stray RVld in IDLE
    @(posedge clk); #1 stray = 1;
    @(posedge clk); #1 stray = 0;
    @(negedge clk);
    chk("stray_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    chk("stray_state_later", dbg_state, 2'd0);
    chk("stray_no_issue", rrdy_cnt - rc, 0);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
